// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

    localparam int PC_W = 8;
    localparam int INST_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 8'd4;

    typedef logic [PC_W-1:0] pc_t;
    typedef logic [INST_W-1:0] inst_t;

    // One queue slot: reserved with its PC at request time, data lands later.
    typedef struct packed {
        pc_t   pc;
        inst_t data;
        logic  filled;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic pc_t align_pc(input pc_t p);
        return {p[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Reservation FIFO: slots are reserved at request time, filled in order by
// responses and popped by decode. Flush empties everything in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         flush_i,
    input  logic         reserve_i,
    input  pc_t          reserve_pc_i,
    input  logic         fill_i,
    input  inst_t        fill_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] unfilled_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  ent_q [DEPTH];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [IW-1:0] fptr_q, fptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] unf_q, unf_d;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy next-state; reserve, fill and pop are independent.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        fptr_d  = fptr_q;
        count_d = count_q;
        unf_d   = unf_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            fptr_d  = '0;
            count_d = '0;
            unf_d   = '0;
        end else begin
            if (reserve_i) tail_d = nxt(tail_q);
            if (fill_i)    fptr_d = nxt(fptr_q);
            if (pop_i)     head_d = nxt(head_q);
            count_d = count_q + CW'(reserve_i) - CW'(pop_i);
            unf_d   = unf_q + CW'(reserve_i) - CW'(fill_i);
        end
    end

    // Pointer/count registers; flush doubles as reset from the parent.
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        fptr_q  <= fptr_d;
        count_q <= count_d;
        unf_q   <= unf_d;
    end

    // Slot storage. Popped slots drop their filled bit so an empty queue
    // never presents a stale head as valid.
    always_ff @(posedge clk) begin
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].filled <= 1'b0;
        end else begin
            if (reserve_i) ent_q[tail_q] <= '{pc: reserve_pc_i, data: '0, filled: 1'b0};
            if (fill_i) begin
                ent_q[fptr_q].data   <= fill_data_i;
                ent_q[fptr_q].filled <= 1'b1;
            end
            if (pop_i) ent_q[head_q].filled <= 1'b0;
        end
    end

    assign head_o     = ent_q[head_q];
    assign count_o    = count_q;
    assign unfilled_o = unf_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, request issue, stale-response dropping and decode handoff.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter int         FIFO_DEPTH = 2,
    parameter int         PC_W       = 8,
    parameter int         INST_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    pc_t           pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] q_count, q_unf;
    logic [CW:0]   occ;
    fetch_entry_t  head;
    logic          req_fire, pop, rsp_take, flush;

    // Outstanding work = queued slots plus responses still owed to a flush.
    // Only registered state feeds the issue decision, so a raised request
    // cannot drop until it is accepted (redirect/reset aside).
    assign occ            = {1'b0, q_count} + {1'b0, drop_q};
    assign imem_req_valid = !rst && !redirect_valid && (occ < (CW+1)'(FIFO_DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = head.filled && !redirect_valid && !rst;
    assign inst_data  = head.data;
    assign inst_pc    = head.pc;
    assign pop        = inst_valid && inst_ready;

    assign flush    = rst || redirect_valid;
    assign rsp_take = imem_rsp_valid && !flush && (drop_q == '0) && (q_unf != '0);

    fetch_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
        .clk          (clk),
        .flush_i      (flush),
        .reserve_i    (req_fire),
        .reserve_pc_i (pc_q),
        .fill_i       (rsp_take),
        .fill_data_i  (imem_rsp_data),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (q_count),
        .unfilled_o   (q_unf)
    );

    // Next PC and drop count. On redirect every unfilled slot becomes a
    // response to discard, less the one arriving right now.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = align_pc(pc_t'(redirect_pc));
            drop_d = drop_q + q_unf
                   - CW'(imem_rsp_valid && ((drop_q != '0) || (q_unf != '0)));
        end else begin
            if (req_fire) pc_d = pc_q + PC_STEP;
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    // Architectural PC and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // Every response must belong to a dropped or a reserved request.
    rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> ((drop_q != '0) || (q_unf != '0)));

endmodule
